w4822_fir: RTL and testbench

64-tap, 16-bit fixed-point FIR filter with loadable coefficients and a single time-multiplexed multiply-accumulator. Input samples arrive at a slow sample rate (clk_slow strobe, nominally clk/128). The block computes y[n] = Σ c[k]·x[n−k], for k = 0..63, using 64 fast-clock MAC cycles per sample. It sits between the sample source (ADC/FPU front end) and the downstream consumer of filtered Q15 data.

---
 rtl/w4822_pkg.sv | 42 ++++
 rtl/w4822_fir_mac.sv | 36 +++
 rtl/w4822_fir.sv | 132 +++++++++++++
 tb/tb_w4822_fir.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/w4822_pkg.sv
// Shared types, sizes and arithmetic helpers for the 64-tap Q15 FIR.
// Latency: n/a (package only).
// Backpressure: n/a.
package w4822_pkg;

  // Filter geometry
  localparam int TAPS = 64;
  localparam int DW   = 16;
  localparam int AW   = 6;

  // Accumulator width: 64 products of 31 magnitude bits need 37 bits, plus sign.
  localparam int ACCW = 38;

  // Q15 output limits expressed at accumulator width for direct comparison.
  localparam logic signed [ACCW-1:0] QMAX = 38'sd32767;
  localparam logic signed [ACCW-1:0] QMIN = -38'sd32768;

  // Rounding constant for round-half-up before dropping 15 fraction bits.
  localparam logic signed [ACCW-1:0] QHALF = 38'sd16384;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Convert a Q30 accumulator to Q15: add half an LSB, arithmetic shift,
  // then clamp into the 16-bit signed range.
  function automatic logic signed [DW-1:0] sat_round(input logic signed [ACCW-1:0] acc);
    logic signed [ACCW-1:0] r;
    r = (acc + QHALF) >>> 15;
    if (r > QMAX) begin
      sat_round = 16'sh7FFF;
    end else if (r < QMIN) begin
      sat_round = 16'sh8000;
    end else begin
      sat_round = r[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/w4822_fir_mac.sv
// Signed 16x16 multiply with 38-bit accumulate and Q15 round/saturate output.
// Latency: one clk per accumulate; res is combinational from the accumulator.
// Backpressure: none; the sequencer drives clr/en directly.
module w4822_fir_mac
  import w4822_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] res
);

  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] acc;

  // Full-precision signed product (Q30).
  assign prod = a * b;

  // Accumulator: clear wins over accumulate so a new sample always starts at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACCW'(prod);
    end
  end

  // Rounded, saturated view of the running sum; sampled by the top in DONE.
  assign res = sat_round(acc);

endmodule

// File: rtl/w4822_fir.sv
// 64-tap Q15 FIR: one sample per start, 64 serial MAC cycles, loadable coefficients.
// Latency: dout/valid update 65 clk edges after the start edge; 66-cycle throughput.
// Backpressure: none; a start arriving while busy is dropped without side effects.
module w4822_fir #(
  parameter int TAPS = 64,
  parameter int DW   = 16,
  parameter int AW   = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_slow,
  input  logic                 valid_in,
  input  logic signed [DW-1:0] din,
  input  logic signed [DW-1:0] cin,
  input  logic        [AW-1:0] caddr,
  input  logic                 cload,
  output logic signed [DW-1:0] dout,
  output logic                 valid
);

  import w4822_pkg::*;

  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

  logic                 clk_slow_q;
  logic                 start_req;
  logic                 start;
  state_t               state;
  logic        [AW-1:0] head;
  logic        [AW-1:0] base;
  logic        [AW-1:0] k;
  logic        [AW-1:0] xidx;
  logic                 mac_en;
  logic signed [DW-1:0] mac_res;
  logic signed [DW-1:0] coef_rd;
  logic signed [DW-1:0] samp_rd;

  logic signed [DW-1:0] cmem  [TAPS];
  logic signed [DW-1:0] xline [TAPS];

  // A start is either a fresh rising edge of the sample strobe or a valid_in
  // pulse; it is only honoured in IDLE, so a busy filter drops the sample.
  assign start_req = (clk_slow & ~clk_slow_q) | valid_in;
  assign start     = start_req & (state == IDLE);

  // base holds the slot of x[n]; x[n-k] lives k slots further on (mod TAPS).
  assign xidx    = base + k;
  assign coef_rd = cmem[k];
  assign samp_rd = xline[xidx];
  assign mac_en  = (state == MAC);

  // Register the strobe so a held-high clk_slow yields exactly one start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_slow_q <= 1'b0;
    end else begin
      clk_slow_q <= clk_slow;
    end
  end

  // Coefficient register file: writable in any state, read asynchronously by tap index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        cmem[i] <= '0;
      end
    end else if (cload) begin
      cmem[caddr] <= cin;
    end
  end

  // Delay line: each accepted sample overwrites the oldest slot at head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        xline[i] <= '0;
      end
    end else if (start) begin
      xline[head] <= din;
    end
  end

  // Sequencer: IDLE -> MAC (TAPS cycles) -> DONE (publish result) -> IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      head  <= '0;
      base  <= '0;
      k     <= '0;
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base  <= head;
            head  <= head - 1'b1;
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          k <= k + 1'b1;
          if (k == LAST_TAP) begin
            state <= DONE;
          end
        end
        DONE: begin
          dout  <= mac_res;
          valid <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Shared multiply-accumulate datapath; cleared on the start edge.
  w4822_fir_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (mac_en),
    .a     (coef_rd),
    .b     (samp_rd),
    .res   (mac_res)
  );

endmodule

// File: tb/tb_w4822_fir.sv
// Scoreboard bench for the 64-tap Q15 FIR: a behavioural model predicts each
// result when a sample is driven; the monitor pops and compares on valid.
module tb_w4822_fir;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        clk_slow = 1'b0;
  logic        valid_in = 1'b0;
  logic        cload    = 1'b0;
  logic [15:0] din      = '0;
  logic [15:0] cin      = '0;
  logic [5:0]  caddr    = '0;
  logic [15:0] dout;
  logic        valid;

  always #5 clk = ~clk;

  w4822_fir #(.TAPS(64), .DW(16), .AW(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_slow (clk_slow),
    .valid_in (valid_in),
    .din      (din),
    .cin      (cin),
    .caddr    (caddr),
    .cload    (cload),
    .dout     (dout),
    .valid    (valid)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk   = 0;
  int   n_err   = 0;
  int   n_valid = 0;

  logic signed [15:0] mc [64];
  logic signed [15:0] mx [64];
  int                 mhead = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mc[i] = '0;
      mx[i] = '0;
    end
    mhead = 0;
  endtask

  // Behavioural filter: insert sample, convolve, round half up, saturate.
  task automatic model_push(input logic [15:0] d, output logic [15:0] e);
    longint acc;
    int     base;
    acc = 0;
    mx[mhead] = d;
    base = mhead;
    mhead = (mhead + 63) % 64;
    for (int k = 0; k < 64; k++) begin
      acc += longint'(mc[k]) * longint'(mx[(base + k) % 64]);
    end
    acc = (acc + 64'sd16384) >>> 15;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    e = acc[15:0];
  endtask

  // Monitor: every valid must match the oldest prediction, value and cycle.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      n_valid++;
      if (sb.size() == 0) begin
        chk("extra_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("dout", {16'h0, dout}, {16'h0, mon_e.d});
        chk("latency", cyc, mon_e.c);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n    = 1'b0;
    clk_slow = 1'b0;
    valid_in = 1'b0;
    cload    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    model_reset();
  endtask

  task automatic load_coef(input int a, input logic [15:0] v);
    @(negedge clk);
    cload = 1'b1;
    caddr = 6'(a);
    cin   = v;
    mc[a] = v;
    @(negedge clk);
    cload = 1'b0;
  endtask

  // Drive one sample; the start edge is the next posedge, result 65 edges later.
  task automatic send(input logic [15:0] d, input bit slow);
    logic [15:0] e;
    wait_idle();
    din = d;
    if (slow) clk_slow = 1'b1;
    else valid_in = 1'b1;
    model_push(d, e);
    sb.push_back('{e, cyc + 66});
    @(negedge clk);
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    clk_slow = 1'b0;
  endtask

  logic [15:0] imp_in  [5];
  logic [15:0] imp_exp [5];
  logic [15:0] tmp_e;
  int          v0;
  int          s_cyc;

  initial begin
    imp_in  = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    imp_exp = '{16'h0000, 16'h0000, 16'h0000, 16'h2000, 16'h0000};
    model_reset();

    // Reset state, then a start on an all-zero filter
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_dout", {16'h0, dout}, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    send(16'h1234, 1'b0);
    wait_idle();
    chk("rst_start", {16'h0, dout}, 32'h0);

    // Single tap
    load_coef(0, 16'h4000);
    send(16'h2000, 1'b1);
    wait_idle();
    chk("single_tap", {16'h0, dout}, 32'h1000);

    // Impulse through tap 3
    reset_dut();
    load_coef(3, 16'h2000);
    for (int i = 0; i < 5; i++) begin
      send(imp_in[i], (i % 2) == 0);
      wait_idle();
      chk("impulse", {16'h0, dout}, {16'h0, imp_exp[i]});
    end

    // Saturation both directions
    for (int i = 0; i < 64; i++) load_coef(i, 16'h7FFF);
    for (int i = 0; i < 64; i++) send(16'h7FFF, 1'b0);
    wait_idle();
    chk("sat_pos", {16'h0, dout}, 32'h7FFF);
    for (int i = 0; i < 64; i++) send(16'h8000, 1'b0);
    wait_idle();
    chk("sat_neg", {16'h0, dout}, 32'h8000);

    // clk_slow held high must not retrigger
    reset_dut();
    load_coef(0, 16'h4000);
    wait_idle();
    v0 = n_valid;
    din = 16'h2000;
    clk_slow = 1'b1;
    model_push(16'h2000, tmp_e);
    sb.push_back('{tmp_e, cyc + 66});
    repeat (150) @(negedge clk);
    clk_slow = 1'b0;
    wait_idle();
    chk("hold_once", n_valid - v0, 32'd1);

    // Busy collision: valid_in 10 cycles into a computation is dropped
    reset_dut();
    load_coef(1, 16'h4000);
    wait_idle();
    v0 = n_valid;
    din = 16'h0800;
    clk_slow = 1'b1;
    model_push(16'h0800, tmp_e);
    sb.push_back('{tmp_e, cyc + 66});
    repeat (2) @(negedge clk);
    clk_slow = 1'b0;
    repeat (8) @(negedge clk);
    din = 16'h1234;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    chk("busy_one", n_valid - v0, 32'd1);
    send(16'h0000, 1'b0);
    wait_idle();
    chk("busy_readback", {16'h0, dout}, 32'h0400);

    // Reset in mid-computation aborts without a valid
    reset_dut();
    load_coef(0, 16'h4000);
    wait_idle();
    chk("pre_midrst", {16'h0, dout}, 32'h0);
    din = 16'h2000;
    valid_in = 1'b1;
    s_cyc = cyc + 1;
    @(negedge clk);
    valid_in = 1'b0;
    while (cyc < s_cyc + 30) @(negedge clk);
    rst_n = 1'b0;
    v0 = n_valid;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (80) @(negedge clk);
    chk("midrst_novalid", n_valid - v0, 32'd0);
    chk("midrst_dout", {16'h0, dout}, 32'h0);
    load_coef(0, 16'h4000);
    send(16'h2000, 1'b1);
    wait_idle();
    chk("midrst_recover", {16'h0, dout}, 32'h1000);

    // Start and coefficient write in the same cycle both take effect
    wait_idle();
    din   = 16'h2000;
    valid_in = 1'b1;
    cload = 1'b1;
    caddr = 6'd0;
    cin   = 16'h2000;
    mc[0] = 16'h2000;
    model_push(16'h2000, tmp_e);
    sb.push_back('{tmp_e, cyc + 66});
    @(negedge clk);
    valid_in = 1'b0;
    cload    = 1'b0;
    wait_idle();
    chk("start_and_load", {16'h0, dout}, 32'h0800);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
